gl_triangle_assembler: RTL and testbench

- Primitive-assembly stage directly upstream of the rasterizer.
- Accepts a stream of 96-bit vertices (x in [95:64], y in [63:32], attribute in [31:0]) and groups them into triangles per the active primitive mode: list, strip or fan.
- Buffers completed triangles in a small FIFO.
- Presents the head triangle on three 96-bit buses with a ready flag, in exactly the form the rasterizer's fifo_in1/2/3 and fifo_ready inputs expect.

---
 rtl/gl_triangle_assembler_if.sv | 31 +++
 rtl/gl_triangle_assembler.sv | 134 +++++++++++++
 tb/tb_gl_triangle_assembler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gl_triangle_assembler_if.sv
// Vertex-in / triangle-out bundle between primitive assembly and the rasterizer.
// The slave view belongs to the assembler; the master view drives it.
interface gl_triangle_assembler_if #(
    parameter int VERTEX_TYPE_SIZE = 96,
    parameter int TRI_DEPTH        = 4
);
    logic                                 prim_start;
    logic [1:0]                           prim_mode;
    logic [VERTEX_TYPE_SIZE-1:0]          vertex_in;
    logic                                 vertex_valid;
    logic                                 vertex_ready;
    logic [VERTEX_TYPE_SIZE-1:0]          fifo_out1;
    logic [VERTEX_TYPE_SIZE-1:0]          fifo_out2;
    logic [VERTEX_TYPE_SIZE-1:0]          fifo_out3;
    logic                                 fifo_ready;
    logic                                 tri_accept;
    logic [$clog2(TRI_DEPTH+1)-1:0]       tri_count;
    logic [31:0]                          tri_total;

    modport master (
        output prim_start, prim_mode, vertex_in, vertex_valid, tri_accept,
        input  vertex_ready, fifo_out1, fifo_out2, fifo_out3, fifo_ready,
               tri_count, tri_total
    );

    modport slave (
        input  prim_start, prim_mode, vertex_in, vertex_valid, tri_accept,
        output vertex_ready, fifo_out1, fifo_out2, fifo_out3, fifo_ready,
               tri_count, tri_total
    );
endinterface

// File: rtl/gl_triangle_assembler.sv
// Groups a vertex stream into list/strip/fan triangles and buffers them in a
// small FIFO whose registered head feeds the rasterizer's fifo_in1/2/3 inputs.
module gl_triangle_assembler #(
    parameter int VERTEX_TYPE_SIZE = 96,
    parameter int TRI_DEPTH        = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    gl_triangle_assembler_if.slave bus
);
    localparam int W     = VERTEX_TYPE_SIZE;
    localparam int PTR_W = $clog2(TRI_DEPTH);
    localparam int CNT_W = $clog2(TRI_DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_LIST  = 2'd0,
        MODE_STRIP = 2'd1,
        MODE_FAN   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [1:0]     n_q, n_d;
    logic           p_q, p_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic           push;
    logic [3*W-1:0] push_tri;

    logic [3*W-1:0]   mem [TRI_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] mem_cnt, occ;
    logic             head_vld;
    logic [3*W-1:0]   head_q;
    logic [31:0]      total_q;
    logic             full, accept, pop, load;

    // Occupancy counts the memory plus the head register, so full is purely registered.
    assign occ    = mem_cnt + CNT_W'(head_vld);
    assign full   = (occ == CNT_W'(TRI_DEPTH));
    assign accept = bus.vertex_valid && !full;
    assign pop    = head_vld && bus.tri_accept;
    assign load   = (!head_vld || pop) && (mem_cnt != '0);

    // Stage: assembly (prim_start overrides first so a same-cycle vertex opens the new primitive)
    always_comb begin
        mode_d   = mode_q;
        n_d      = n_q;
        p_d      = p_q;
        a_d      = a_q;
        b_d      = b_q;
        push     = 1'b0;
        push_tri = {a_q, b_q, bus.vertex_in};
        if (bus.prim_start) begin
            mode_d = mode_e'(bus.prim_mode);
            n_d    = 2'd0;
            p_d    = 1'b0;
        end
        if (accept && mode_d != MODE_RSVD) begin
            if (n_d == 2'd0) begin
                a_d = bus.vertex_in;
                n_d = 2'd1;
            end else if (n_d == 2'd1) begin
                b_d = bus.vertex_in;
                n_d = 2'd2;
            end else begin
                push = 1'b1;
                case (mode_d)
                    MODE_STRIP: begin
                        if (p_d) push_tri = {b_q, a_q, bus.vertex_in};
                        a_d = b_q;
                        b_d = bus.vertex_in;
                        p_d = ~p_d;
                    end
                    MODE_FAN: b_d = bus.vertex_in;
                    default:  n_d = 2'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_LIST;
            n_q    <= 2'd0;
            p_q    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            mode_q <= mode_d;
            n_q    <= n_d;
            p_q    <= p_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    // Stage: triangle FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tri;
    end

    // Stage: registered head; memory entries reach the head one cycle after the push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            head_vld <= 1'b0;
            head_q   <= '0;
            total_q  <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                total_q <= total_q + 32'd1;
            end
            mem_cnt <= mem_cnt + CNT_W'(push) - CNT_W'(load);
            if (load) begin
                head_q   <= mem[rd_ptr];
                head_vld <= 1'b1;
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (pop) begin
                head_vld <= 1'b0;
            end
        end
    end

    assign bus.vertex_ready = !full;
    assign bus.fifo_ready   = head_vld;
    assign bus.fifo_out1    = head_q[3*W-1:2*W];
    assign bus.fifo_out2    = head_q[2*W-1:W];
    assign bus.fifo_out3    = head_q[W-1:0];
    assign bus.tri_count    = occ;
    assign bus.tri_total    = total_q;
endmodule

// File: tb/tb_gl_triangle_assembler.sv
// Directed bench for gl_triangle_assembler: list/strip/fan assembly, backpressure,
// primitive restart and asynchronous reset, against hand-computed triangles.
module tb_gl_triangle_assembler;
    localparam int VW = 96;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    gl_triangle_assembler_if #(.VERTEX_TYPE_SIZE(VW), .TRI_DEPTH(TD)) bus ();

    gl_triangle_assembler #(.VERTEX_TYPE_SIZE(VW), .TRI_DEPTH(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [287:0] head_w;
    assign head_w = {bus.fifo_out1, bus.fifo_out2, bus.fifo_out3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [95:0] v, input logic ps, input logic [1:0] mode);
        bus.prim_start   = ps;
        bus.prim_mode    = mode;
        bus.vertex_in    = v;
        bus.vertex_valid = 1'b1;
        tick();
        bus.prim_start   = 1'b0;
        bus.vertex_valid = 1'b0;
    endtask

    function automatic logic [95:0] vx(input logic [31:0] x, input logic [31:0] y, input logic [31:0] at);
        return {x, y, at};
    endfunction

    logic [95:0] fl[6];
    logic [95:0] sv[5];
    logic [95:0] fv[5];
    logic [95:0] uv[15];
    logic [95:0] pv[6];
    logic [95:0] s2[5];
    logic [95:0] rv[3];
    int   k;
    int   drop_c;
    logic acc;

    initial begin
        fl[0] = vx(32'h3F80_0000, 32'h0, 32'h0);
        fl[1] = vx(32'h4000_0000, 32'h0, 32'h0);
        fl[2] = vx(32'h4040_0000, 32'h0, 32'h0);
        fl[3] = vx(32'h4080_0000, 32'h0, 32'h0);
        fl[4] = vx(32'h40A0_0000, 32'h0, 32'h0);
        fl[5] = vx(32'h40C0_0000, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            sv[i] = vx(32'h100 + i, 32'h200 + i, 32'h300 + i);
            fv[i] = vx(32'h400 + i, 32'h500 + i, 32'h600 + i);
            s2[i] = vx(32'hA00 + i, 32'hB00 + i, 32'hC00 + i);
        end
        for (int i = 0; i < 15; i++) uv[i] = vx(32'h700 + i, 32'h800 + i, 32'h900 + i);
        for (int i = 0; i < 6; i++)  pv[i] = vx(32'hD00 + i, 32'hE00 + i, 32'hF00 + i);
        for (int i = 0; i < 3; i++)  rv[i] = vx(32'h1100 + i, 32'h1200 + i, 32'h1300 + i);

        rst_n            = 1'b0;
        bus.prim_start   = 1'b0;
        bus.prim_mode    = 2'd0;
        bus.vertex_in    = '0;
        bus.vertex_valid = 1'b0;
        bus.tri_accept   = 1'b0;
        tick();
        tick();
        chk("rst_vertex_ready", 288'(bus.vertex_ready), 288'(1));
        chk("rst_fifo_ready",   288'(bus.fifo_ready),   288'(0));
        chk("rst_head",         head_w,                 288'(0));
        chk("rst_tri_count",    288'(bus.tri_count),    288'(0));
        chk("rst_tri_total",    288'(bus.tri_total),    288'(0));
        rst_n = 1'b1;
        tick();

        // List mode
        send(fl[0], 1'b1, 2'd0);
        send(fl[1], 1'b0, 2'd0);
        send(fl[2], 1'b0, 2'd0);
        chk("list_ready_latency", 288'(bus.fifo_ready), 288'(0));
        bus.tri_accept = 1'b1;
        send(fl[3], 1'b0, 2'd0);
        chk("list_ready_rise", 288'(bus.fifo_ready), 288'(1));
        chk("list_tri1",       head_w, {fl[0], fl[1], fl[2]});
        chk("list_total1",     288'(bus.tri_total), 288'(1));
        send(fl[4], 1'b0, 2'd0);
        chk("list_empty_after_pop", 288'(bus.fifo_ready), 288'(0));
        chk("list_hold_outputs",    head_w, {fl[0], fl[1], fl[2]});
        send(fl[5], 1'b0, 2'd0);
        tick();
        chk("list_tri2",   head_w, {fl[3], fl[4], fl[5]});
        chk("list_total2", 288'(bus.tri_total), 288'(2));
        tick();
        chk("list_drained", 288'(bus.tri_count), 288'(0));
        bus.tri_accept = 1'b0;

        // Strip mode
        send(sv[0], 1'b1, 2'd1);
        for (int i = 1; i < 5; i++) send(sv[i], 1'b0, 2'd1);
        chk("strip_count", 288'(bus.tri_count), 288'(3));
        chk("strip_total", 288'(bus.tri_total), 288'(5));
        chk("strip_tri1",  head_w, {sv[0], sv[1], sv[2]});
        bus.tri_accept = 1'b1;
        tick();
        chk("strip_tri2", head_w, {sv[2], sv[1], sv[3]});
        tick();
        chk("strip_tri3", head_w, {sv[2], sv[3], sv[4]});
        tick();
        chk("strip_drained", 288'(bus.fifo_ready), 288'(0));
        bus.tri_accept = 1'b0;

        // Fan mode
        send(fv[0], 1'b1, 2'd2);
        for (int i = 1; i < 5; i++) send(fv[i], 1'b0, 2'd2);
        chk("fan_tri1", head_w, {fv[0], fv[1], fv[2]});
        bus.tri_accept = 1'b1;
        tick();
        chk("fan_tri2", head_w, {fv[0], fv[2], fv[3]});
        tick();
        chk("fan_tri3", head_w, {fv[0], fv[3], fv[4]});
        tick();
        chk("fan_drained", 288'(bus.fifo_ready), 288'(0));
        chk("fan_total",   288'(bus.tri_total), 288'(8));
        bus.tri_accept = 1'b0;

        // Backpressure: list mode, nothing drained
        k      = 0;
        drop_c = -1;
        for (int c = 0; c < 14; c++) begin
            bus.prim_start   = (c == 0);
            bus.prim_mode    = 2'd0;
            bus.vertex_in    = uv[k];
            bus.vertex_valid = 1'b1;
            acc              = bus.vertex_ready;
            if (!acc && drop_c < 0) drop_c = c;
            tick();
            if (acc) k++;
        end
        bus.prim_start = 1'b0;
        chk("bp_drop_cycle", 288'(drop_c), 288'(12));
        chk("bp_accepted",   288'(k), 288'(12));
        chk("bp_ready_low",  288'(bus.vertex_ready), 288'(0));
        chk("bp_count_full", 288'(bus.tri_count), 288'(4));
        bus.tri_accept = 1'b1;
        tick();
        bus.tri_accept = 1'b0;
        chk("bp_ready_back", 288'(bus.vertex_ready), 288'(1));
        chk("bp_count_pop",  288'(bus.tri_count), 288'(3));
        chk("bp_head_pop",   head_w, {uv[3], uv[4], uv[5]});
        for (int c = 0; c < 4; c++) begin
            bus.vertex_in    = uv[(k < 15) ? k : 14];
            bus.vertex_valid = 1'b1;
            acc              = bus.vertex_ready;
            tick();
            if (acc) k++;
        end
        bus.vertex_valid = 1'b0;
        chk("bp_accepted_all", 288'(k), 288'(15));
        chk("bp_refull",       288'(bus.vertex_ready), 288'(0));
        bus.tri_accept = 1'b1;
        for (int j = 1; j < 5; j++) begin
            chk($sformatf("bp_order%0d", j), head_w, {uv[3*j], uv[3*j+1], uv[3*j+2]});
            tick();
        end
        chk("bp_drained", 288'(bus.fifo_ready), 288'(0));
        chk("bp_total",   288'(bus.tri_total), 288'(13));
        bus.tri_accept = 1'b0;

        // prim_start abandons a partial list triangle; same-cycle vertex is the fan hub
        send(pv[0], 1'b0, 2'd0);
        send(pv[1], 1'b0, 2'd0);
        send(pv[2], 1'b1, 2'd2);
        send(pv[3], 1'b0, 2'd0);
        chk("restart_no_tri", 288'(bus.tri_total), 288'(13));
        send(pv[4], 1'b0, 2'd0);
        send(pv[5], 1'b0, 2'd0);
        chk("restart_tri1",  head_w, {pv[2], pv[3], pv[4]});
        chk("restart_count", 288'(bus.tri_count), 288'(2));
        bus.tri_accept = 1'b1;
        tick();
        chk("restart_tri2", head_w, {pv[2], pv[4], pv[5]});
        tick();
        chk("restart_drained", 288'(bus.fifo_ready), 288'(0));
        chk("restart_total",   288'(bus.tri_total), 288'(15));
        bus.tri_accept = 1'b0;

        // Asynchronous reset mid-strip with three triangles buffered
        send(s2[0], 1'b1, 2'd1);
        for (int i = 1; i < 5; i++) send(s2[i], 1'b0, 2'd1);
        chk("mid_count_before", 288'(bus.tri_count), 288'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fifo_ready",   288'(bus.fifo_ready),   288'(0));
        chk("mid_rst_count",        288'(bus.tri_count),    288'(0));
        chk("mid_rst_total",        288'(bus.tri_total),    288'(0));
        chk("mid_rst_vertex_ready", 288'(bus.vertex_ready), 288'(1));
        chk("mid_rst_head",         head_w,                 288'(0));
        tick();
        rst_n = 1'b1;
        send(rv[0], 1'b0, 2'd0);
        send(rv[1], 1'b0, 2'd0);
        chk("post_rst_two_verts", 288'(bus.tri_total), 288'(0));
        send(rv[2], 1'b0, 2'd0);
        chk("post_rst_push",  288'(bus.tri_total), 288'(1));
        chk("post_rst_latch", 288'(bus.fifo_ready), 288'(0));
        tick();
        chk("post_rst_tri", head_w, {rv[0], rv[1], rv[2]});
        chk("post_rst_ready", 288'(bus.fifo_ready), 288'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
